// File: rtl/shifter_pkg.sv
// Shared definitions for the 8-bit shifter and its command issuer:
// field widths, op-code constants and the issuer FSM state type.
package shifter_pkg;

    localparam int OP_W    = 3;
    localparam int SHAMT_W = 2;
    localparam int DATA_W  = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_LSL  = 3'b010;
    localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ASR  = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_e;

    // Undefined op codes degrade to NOP so the shifter only ever sees legal ops.
    function automatic logic [OP_W-1:0] sanitize_op(input logic [OP_W-1:0] op);
        return (op > OP_ASR) ? OP_NOP : op;
    endfunction

endpackage

// File: rtl/shift_cmd_issuer_if.sv
// Valid/ready command channel into the shift command issuer.
interface shift_cmd_issuer_if #(
    parameter int CNT_W = 4
);
    import shifter_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [SHAMT_W-1:0]  cmd_shamt;
    logic [DATA_W-1:0]   cmd_data;
    logic [CNT_W-1:0]    cmd_rpt;

    modport master (
        output cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
        output cmd_ready
    );

endinterface

// File: rtl/shift_cmd_issuer_fifo.sv
// Synchronous FIFO for packed shift commands. Occupancy is tracked by an
// explicit count so full and empty never depend on pointer equality.
module shift_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written, and the count gates that.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/shift_cmd_issuer.sv
// Buffers shift commands and replays each one onto the shifter inputs for its
// repeat count, chaining queued commands with no idle cycle between them.
module shift_cmd_issuer
    import shifter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    shift_cmd_issuer_if.slave          cmd,
    output logic [OP_W-1:0]            issue_op,
    output logic [SHAMT_W-1:0]         issue_shamt,
    output logic [DATA_W-1:0]          issue_d_in,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int ENTRY_W = OP_W + SHAMT_W + DATA_W + CNT_W;

    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;

    logic [OP_W-1:0]    head_op;
    logic [SHAMT_W-1:0] head_shamt;
    logic [DATA_W-1:0]  head_data;
    logic [CNT_W-1:0]   head_rpt;

    issue_state_e       state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               last_cycle;

    // Ready is a plain registered-count compare: a full FIFO never passes a push through on a pop.
    assign cmd.cmd_ready = !fifo_full;
    assign fifo_push     = cmd.cmd_valid && !fifo_full;
    assign fifo_wdata    = {sanitize_op(cmd.cmd_op), cmd.cmd_shamt, cmd.cmd_data, cmd.cmd_rpt};

    shift_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign {head_op, head_shamt, head_data, head_rpt} = fifo_rdata;
    assign last_cycle = (state_q == ST_ISSUE) && (remaining_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shamt_d     = shamt_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                remaining_d = remaining_q - CNT_W'(1);
                if (last_cycle) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        op_d    = '0;
                        shamt_d = '0;
                        data_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop in either state loads the head directly into the active registers.
        if (fifo_pop) begin
            op_d        = head_op;
            shamt_d     = head_shamt;
            data_d      = head_data;
            remaining_d = (head_rpt == '0) ? CNT_W'(1) : head_rpt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            shamt_q     <= '0;
            data_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            shamt_q     <= shamt_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
        end
    end

    // Active registers are zeroed whenever the FSM drops to IDLE, so they drive the shifter directly.
    assign issue_op    = op_q;
    assign issue_shamt = shamt_q;
    assign issue_d_in  = data_q;
    assign busy        = (state_q == ST_ISSUE);
    assign done        = last_cycle;

endmodule

// File: doc/shift_cmd_issuer.md
# shift_cmd_issuer

Command sequencer directly upstream of the 8-bit shifter. Accepts shift commands (op, shift amount, data, repeat count) over a valid/ready handshake, buffers them in a small FIFO, and drives the shifter's `op`/`shamt`/`d_in` inputs cycle by cycle. Each command is applied for its programmed number of consecutive cycles. Commands issue back-to-back with no idle cycles between them.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, at least 2.
- `CNT_W`, 4: repeat-count width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present on the `cmd_*` inputs.
- `cmd_ready`  out  1  issuer can accept a command this cycle.
- `cmd_op`  in  3  shifter op code.
- `cmd_shamt`  in  2  shift amount.
- `cmd_data`  in  8  data for LOAD.
- `cmd_rpt`  in  CNT_W  number of cycles to apply the op; 0 is treated as 1.
- `issue_op`  out  3  to shifter `op`.
- `issue_shamt`  out  2  to shifter `shamt`.
- `issue_d_in`  out  8  to shifter `d_in`.
- `busy`  out  1  a command is being issued.
- `done`  out  1  one-cycle pulse during the last issue cycle of each command.
- `fifo_count`  out  $clog2(DEPTH)+1  number of queued commands, excluding the active one.

## Operation
- Op encoding: 000 NOP/hold, 001 LOAD, 010 LSL, 011 LSR, 100 ASR.
- Op codes 101–111 are accepted but stored as 000 (NOP) at enqueue.
- Push rule: a command is pushed when `cmd_valid && cmd_ready`.
  - `cmd_ready = (fifo_count < DEPTH)`. It is a registered-count compare with no pass-through when full.
- FSM has two states, IDLE and ISSUE.
- In IDLE:
  - If the FIFO is non-empty, pop the head into the active registers and set `remaining = max(rpt,1)`. Next state is ISSUE.
  - If the FIFO is empty, stay in IDLE.
- In ISSUE:
  - Each cycle, decrement `remaining`.
  - When `remaining == 1` the current cycle is the last one, and `done` is 1.
  - At the end of that last cycle: if the FIFO is non-empty, pop the next command in the same edge and stay in ISSUE with no bubble. Otherwise go to IDLE.
- Outputs are registered from the state and active registers:
  - In ISSUE, `issue_*` carry the active command.
  - In IDLE, `issue_op`, `issue_shamt` and `issue_d_in` are all 0.
  - `busy = (state == ISSUE)`.
- Simultaneous push and pop: `fifo_count` is unchanged and both operations take effect.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the count, not by pointer equality.
- Reset values: state IDLE, FIFO empty, `fifo_count` 0, `issue_*` 0, `busy` 0, `done` 0. `cmd_ready` is 1 from the first cycle after reset deasserts.
- Reset mid-command: the active command and all queued commands are discarded. `done` is not pulsed, and the outputs are 0 in the cycle after the reset edge.

## Timing
- Latency from an empty, idle issuer:
  - The command is accepted at edge k.
  - It is popped at edge k+1.
  - `issue_op` shows it in the cycle following edge k+1.
- A command with repeat R (R ≥ 1) holds `issue_op`, `issue_shamt` and `issue_d_in` constant for exactly R consecutive cycles.
- `done` is high in the same cycle as the R-th issue.
- Back-to-back commands: the first cycle of command n+1 directly follows the last cycle of command n.
- Throughput: at most one command per cycle when R = 1.

## Structure
- Shared package `shifter_pkg`:
  - op-code constants `OP_NOP`, `OP_LOAD`, `OP_LSL`, `OP_LSR`, `OP_ASR`;
  - `OP_W = 3`, `SHAMT_W = 2`, `DATA_W = 8`.
- The shifter uses the same package.
- One sub-module: `shift_cmd_fifo`.
  - Synchronous FIFO with parameterised width and depth, storing the packed {op, shamt, data, rpt}.
  - Exposes push, pop, count, empty and full.
- The FSM, repeat counter and output registers live in the top module.

## Test plan
1. Reset held for 2 cycles, then released → all `issue_*` = 0, `busy` = 0, `done` = 0, `fifo_count` = 0, `cmd_ready` = 1.
2. Push LOAD data 8'h77 rpt 1, then LSL shamt 1 rpt 3, with the shifter attached → `issue_op` sequence is 001, 010, 010, 010, 000.
   - Shifter `d_out` sequence is 77, EE, DC, B8.
   - `done` pulses on the 1st and 4th issue cycles.
3. Push ASR shamt 3 rpt 15, then push 4 further commands while it issues → `fifo_count` reaches 4 and `cmd_ready` = 0.
   - A 5th push is held (not accepted) until the first pop after the ASR completes.
4. Push two commands, each with rpt 2 → 4 consecutive non-NOP cycles, `busy` continuously 1, 2 `done` pulses, then `issue_op` = 000.
5. Push op 3'b111 rpt 0 → exactly one issue cycle with `issue_op` = 000, `busy` = 1 and `done` = 1.
6. Assert reset on the 3rd cycle of an LSR rpt 8 command with 2 commands queued → the next cycle has all outputs 0 and `fifo_count` = 0.
   - No `done` pulse occurs.
   - The queued commands are never issued.
